spislave: RTL

SPI responder (slave) for the Bus Pirate IO pins, and the opposite end of the existing `spimaster`. It oversamples an external SCLK, CS and MOSI on the system clock and pushes each received byte into a FIFO-style write port. Transmit bytes are popped from a FIFO-style read port and shifted out on MISO. It sits between the `iobuf` pin layer and the FIFO_OUT / FIFO_IN pair, so the MCU can emulate an SPI peripheral or capture host traffic.

---
 rtl/spislave.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spislave.sv
`timescale 1ns/1ps
// SPI responder: oversamples SCLK/CS/MOSI on the system clock, pushes received bytes to an RX FIFO
// port and shifts TX FIFO bytes out on MISO. Optional LSB-first support under SPI_SLAVE_LSB_FIRST_EN.
module spislave #(
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpol,
  input  logic       cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic       lsb_first,
`endif
  input  logic       spi_sclk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_shift,
  input  logic       rx_full,
  input  logic [7:0] tx_data,
  input  logic       tx_nempty,
  output logic       tx_pop,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       clr_status,
  output logic       busy,
  output logic       frame_end
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic       w_lsb;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_lsb = lsb_first;
`else
  assign w_lsb = 1'b0;
`endif

  function automatic logic [7:0] f_rx_next(input logic [7:0] sr, input logic din, input logic lsb);
    return lsb ? {din, sr[7:1]} : {sr[6:0], din};
  endfunction

  function automatic logic [7:0] f_tx_next(input logic [7:0] sr, input logic lsb);
    return lsb ? {1'b0, sr[7:1]} : {sr[6:0], 1'b0};
  endfunction

  logic       r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic       r_cs_p0, r_cs_p1, r_cs_p2;
  logic       r_mosi_p0, r_mosi_p1;
  logic       r_sample_p3, r_shift_p3, r_cs_fall_p3, r_cs_rise_p3, r_mosi_p3;
  logic       w_sclk_edge, w_lead, w_trail;
  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_load_pend;
  logic [7:0] r_rx_sr, r_tx_sr;
  logic [7:0] w_rx_next, w_tx_load;

  assign w_sclk_edge = r_sclk_p1 ^ r_sclk_p2;
  assign w_lead      = w_sclk_edge & (r_sclk_p1 ^ cpol);
  assign w_trail     = w_sclk_edge & ~(r_sclk_p1 ^ cpol);
  assign w_rx_next   = f_rx_next(r_rx_sr, r_mosi_p3, w_lsb);
  assign w_tx_load   = tx_nempty ? tx_data : FILL;
  assign spi_miso    = w_lsb ? r_tx_sr[0] : r_tx_sr[7];

  // p0/p1: two-flop synchronizers, p2: history for edge detect.
  // CS resets low so a frame left open across reset is not mistaken for a new CS fall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sclk_p0 <= 1'b0;
      r_sclk_p1 <= 1'b0;
      r_sclk_p2 <= 1'b0;
      r_cs_p0   <= 1'b0;
      r_cs_p1   <= 1'b0;
      r_cs_p2   <= 1'b0;
      r_mosi_p0 <= 1'b0;
      r_mosi_p1 <= 1'b0;
    end else begin
      r_sclk_p0 <= spi_sclk;
      r_sclk_p1 <= r_sclk_p0;
      r_sclk_p2 <= r_sclk_p1;
      r_cs_p0   <= spi_cs;
      r_cs_p1   <= r_cs_p0;
      r_cs_p2   <= r_cs_p1;
      r_mosi_p0 <= spi_mosi;
      r_mosi_p1 <= r_mosi_p0;
    end
  end

  // p3: registered edge events, MOSI captured alongside the SCLK edge it belongs to
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sample_p3  <= 1'b0;
      r_shift_p3   <= 1'b0;
      r_cs_fall_p3 <= 1'b0;
      r_cs_rise_p3 <= 1'b0;
      r_mosi_p3    <= 1'b0;
    end else begin
      r_sample_p3  <= cpha ? w_trail : w_lead;
      r_shift_p3   <= cpha ? w_lead : w_trail;
      r_cs_fall_p3 <= r_cs_p2 & ~r_cs_p1;
      r_cs_rise_p3 <= ~r_cs_p2 & r_cs_p1;
      r_mosi_p3    <= r_mosi_p1;
    end
  end

  // p4: frame FSM, shift registers, strobes and sticky flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_load_pend <= 1'b0;
      r_rx_sr     <= 8'h00;
      r_tx_sr     <= 8'h00;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= 8'h00;
      rx_shift    <= 1'b0;
      tx_pop      <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      rx_shift  <= 1'b0;
      tx_pop    <= 1'b0;
      frame_end <= 1'b0;
      // A set later in this block overrides the clear when both happen together
      if (clr_status) begin
        rx_overrun  <= 1'b0;
        tx_underrun <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_cs_fall_p3) begin
            r_state     <= S_ACTIVE;
            spi_miso_oe <= 1'b1;
            busy        <= 1'b1;
            r_cnt       <= 3'd0;
            r_load_pend <= 1'b0;
            if (!cpha) begin
              r_tx_sr <= w_tx_load;
              if (tx_nempty) tx_pop <= 1'b1;
              else           tx_underrun <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (r_cs_rise_p3) begin
            r_state     <= S_IDLE;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            r_cnt       <= 3'd0;
            r_load_pend <= 1'b0;
            frame_end   <= 1'b1;
          end else begin
            if (r_sample_p3) begin
              r_rx_sr <= w_rx_next;
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                rx_data <= w_rx_next;
                if (!rx_full) rx_shift <= 1'b1;
                else          rx_overrun <= 1'b1;
                if (!cpha) r_load_pend <= 1'b1;
              end
            end
            if (r_shift_p3) begin
              if (cpha ? (r_cnt == 3'd0) : r_load_pend) begin
                r_load_pend <= 1'b0;
                r_tx_sr     <= w_tx_load;
                if (tx_nempty) tx_pop <= 1'b1;
                else           tx_underrun <= 1'b1;
              end else begin
                r_tx_sr <= f_tx_next(r_tx_sr, w_lsb);
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
